// File: rtl/snn_first_layer_pkg.sv
// Shared defaults and FSM state encoding for the first-layer synapse sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package snn_first_layer_pkg;

    localparam int DEF_NEURON_NUM = 40;    // post-neurons in the layer / offset memory depth
    localparam int DEF_TOTAL_SYN  = 1000;  // end bound of the last neuron's synapse range
    localparam int DEF_ADDR_W     = 6;     // offset memory address / neuron index width
    localparam int DEF_SYN_W      = 10;    // offset data / synapse address width

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RD0    = 3'd1,
        RDEND  = 3'd2,
        CHK    = 3'd3,
        STREAM = 3'd4,
        NDONE  = 3'd5,
        FIN    = 3'd6
    } seq_state_t;

endpackage

// File: rtl/first_layer_synapse_sequencer.sv
// Walks neurons 0..NEURON_NUM-1 and streams each neuron's synapse addresses from the offset table.
// Latency: start -> first syn_valid 4 cycles; per neuron ~4 cycles of overhead plus one cycle per beat.
// Backpressure: syn_valid/syn_ready; an unaccepted beat holds syn_addr/syn_last/neuron_idx stable.
module first_layer_synapse_sequencer
    import snn_first_layer_pkg::*;
#(
    parameter int NEURON_NUM = DEF_NEURON_NUM,
    parameter int TOTAL_SYN  = DEF_TOTAL_SYN,
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int SYN_W      = DEF_SYN_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [ADDR_W-1:0] offset_addr,
    input  logic [SYN_W-1:0]  offset_data,
    output logic [SYN_W-1:0]  syn_addr,
    output logic              syn_valid,
    input  logic              syn_ready,
    output logic              syn_last,
    output logic [ADDR_W-1:0] neuron_idx,
    output logic              neuron_done,
    output logic              busy,
    output logic              done
);

    localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(NEURON_NUM - 1);
    localparam logic [SYN_W-1:0]  TOTAL_END = SYN_W'(TOTAL_SYN);

    seq_state_t        state, state_nxt;
    logic              rd_wait, rd_wait_nxt;   // first cycle of a read state waits for memory latency
    logic [SYN_W-1:0]  cur_syn, cur_nxt;       // next synapse address to issue
    logic [SYN_W-1:0]  end_syn, end_nxt;       // exclusive end of the current neuron's range
    logic [ADDR_W-1:0] addr_nxt, idx_nxt;
    logic              beat_last;

    // The final beat is the one just below the end bound; only meaningful while streaming (cur < end).
    assign beat_last = (cur_syn == (end_syn - SYN_W'(1)));

    // Outputs are decoded from state so a reset clears them on the very next cycle.
    assign syn_valid   = (state == STREAM);
    assign syn_addr    = syn_valid ? cur_syn : '0;
    assign syn_last    = syn_valid & beat_last;
    assign neuron_done = (state == NDONE);
    assign done        = (state == FIN);
    assign busy        = (state != IDLE);

    // Next-state and datapath updates for the neuron walk.
    always_comb begin
        state_nxt   = state;
        rd_wait_nxt = 1'b0;
        cur_nxt     = cur_syn;
        end_nxt     = end_syn;
        addr_nxt    = offset_addr;
        idx_nxt     = neuron_idx;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = RD0;
                    addr_nxt  = '0;
                    idx_nxt   = '0;
                end
            end
            RD0: begin
                if (!rd_wait) begin
                    rd_wait_nxt = 1'b1;
                end else begin
                    cur_nxt = offset_data;
                    if (NEURON_NUM > 1) begin
                        addr_nxt  = ADDR_W'(1);
                        state_nxt = RDEND;
                    end else begin
                        end_nxt   = TOTAL_END;
                        state_nxt = CHK;
                    end
                end
            end
            RDEND: begin
                if (!rd_wait) begin
                    rd_wait_nxt = 1'b1;
                end else begin
                    end_nxt   = offset_data;
                    state_nxt = CHK;
                end
            end
            CHK: begin
                // A malformed table (end below start) is treated as an empty neuron, never wrapped.
                state_nxt = (cur_syn >= end_syn) ? NDONE : STREAM;
            end
            STREAM: begin
                if (syn_ready) begin
                    cur_nxt = cur_syn + SYN_W'(1);
                    if (beat_last) begin
                        state_nxt = NDONE;
                    end
                end
            end
            NDONE: begin
                if (neuron_idx == LAST_IDX) begin
                    state_nxt = FIN;
                end else begin
                    // Next neuron starts where this one ended, so only its end bound is fetched.
                    idx_nxt = neuron_idx + ADDR_W'(1);
                    cur_nxt = end_syn;
                    if ((neuron_idx + ADDR_W'(1)) == LAST_IDX) begin
                        end_nxt   = TOTAL_END;
                        state_nxt = CHK;
                    end else begin
                        addr_nxt  = neuron_idx + ADDR_W'(2);
                        state_nxt = RDEND;
                    end
                end
            end
            FIN: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            rd_wait     <= 1'b0;
            cur_syn     <= '0;
            end_syn     <= '0;
            offset_addr <= '0;
            neuron_idx  <= '0;
        end else begin
            state       <= state_nxt;
            rd_wait     <= rd_wait_nxt;
            cur_syn     <= cur_nxt;
            end_syn     <= end_nxt;
            offset_addr <= addr_nxt;
            neuron_idx  <= idx_nxt;
        end
    end

endmodule

// File: tb/tb_first_layer_synapse_sequencer.sv
// Directed bench for first_layer_synapse_sequencer across three table configurations.
// Latency: checks start -> first beat on the single-neuron configuration.
// Backpressure: drives syn_ready both constant and alternating.
module tb_first_layer_synapse_sequencer;

    logic clk;
    logic rst;

    // Main configuration: 4 neurons, 10 synapses, offsets {0,3,3,7}
    logic       start_a, ready_a;
    logic [5:0] a_offset_addr, a_neuron_idx;
    logic [9:0] a_offset_data, a_syn_addr;
    logic       a_syn_valid, a_syn_last, a_neuron_done, a_busy, a_done;

    // All-empty configuration: 4 neurons, 0 synapses
    logic       start_z, ready_z;
    logic [5:0] z_offset_addr, z_neuron_idx;
    logic [9:0] z_offset_data, z_syn_addr;
    logic       z_syn_valid, z_syn_last, z_neuron_done, z_busy, z_done;

    // Single-neuron configuration: 1 neuron, 2 synapses
    logic       start_o, ready_o;
    logic [5:0] o_offset_addr, o_neuron_idx;
    logic [9:0] o_offset_data, o_syn_addr;
    logic       o_syn_valid, o_syn_last, o_neuron_done, o_busy, o_done;

    logic [9:0] mem_a [4] = '{10'd0, 10'd3, 10'd3, 10'd7};

    int exp_idx      [10] = '{0, 0, 0, 2, 2, 2, 2, 3, 3, 3};
    int exp_last     [10] = '{0, 0, 1, 0, 0, 0, 1, 0, 0, 1};
    int exp_nd_beats [4]  = '{3, 3, 7, 10};

    int n_cmp = 0;
    int n_err = 0;

    first_layer_synapse_sequencer #(.NEURON_NUM(4), .TOTAL_SYN(10), .ADDR_W(6), .SYN_W(10)) u_dut_a (
        .clk(clk), .rst(rst), .start(start_a),
        .offset_addr(a_offset_addr), .offset_data(a_offset_data),
        .syn_addr(a_syn_addr), .syn_valid(a_syn_valid), .syn_ready(ready_a), .syn_last(a_syn_last),
        .neuron_idx(a_neuron_idx), .neuron_done(a_neuron_done), .busy(a_busy), .done(a_done)
    );

    first_layer_synapse_sequencer #(.NEURON_NUM(4), .TOTAL_SYN(0), .ADDR_W(6), .SYN_W(10)) u_dut_z (
        .clk(clk), .rst(rst), .start(start_z),
        .offset_addr(z_offset_addr), .offset_data(z_offset_data),
        .syn_addr(z_syn_addr), .syn_valid(z_syn_valid), .syn_ready(ready_z), .syn_last(z_syn_last),
        .neuron_idx(z_neuron_idx), .neuron_done(z_neuron_done), .busy(z_busy), .done(z_done)
    );

    first_layer_synapse_sequencer #(.NEURON_NUM(1), .TOTAL_SYN(2), .ADDR_W(6), .SYN_W(10)) u_dut_o (
        .clk(clk), .rst(rst), .start(start_o),
        .offset_addr(o_offset_addr), .offset_data(o_offset_data),
        .syn_addr(o_syn_addr), .syn_valid(o_syn_valid), .syn_ready(ready_o), .syn_last(o_syn_last),
        .neuron_idx(o_neuron_idx), .neuron_done(o_neuron_done), .busy(o_busy), .done(o_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Offset memories with one-cycle read latency; out-of-range addresses return a poison value.
    always_ff @(posedge clk) begin
        a_offset_data <= (a_offset_addr < 6'd4) ? mem_a[a_offset_addr[1:0]] : 10'h3ff;
        z_offset_data <= (z_offset_addr < 6'd4) ? 10'd0 : 10'h3ff;
        o_offset_data <= (o_offset_addr == 6'd0) ? 10'd0 : 10'h3ff;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // One layer pass on the main configuration. toggle_ready alternates syn_ready,
    // restart pulses start mid-pass, abort_addr >= 0 asserts rst when that address is presented.
    task automatic run_a(input bit toggle_ready, input bit restart, input int abort_addr);
        int         nbeat = 0;
        int         nd_cnt = 0;
        int         done_cnt = 0;
        int         tail = 0;
        int         max_addr = 0;
        int         cyc;
        bit         got_done = 1'b0;
        bit         aborted = 1'b0;
        bit         prev_stall = 1'b0;
        logic [9:0] prev_addr = '0;
        logic       prev_last = 1'b0;
        logic [5:0] prev_idx = '0;
        start_a = 1'b1;
        for (cyc = 0; cyc < 400 && tail < 10 && !aborted; cyc++) begin
            @(negedge clk);
            start_a = restart && (cyc == 12);
            if (int'(a_offset_addr) > max_addr) max_addr = int'(a_offset_addr);
            if (prev_stall) begin
                chk("hold_valid", a_syn_valid, 1);
                chk("hold_addr", a_syn_addr, prev_addr);
                chk("hold_last", a_syn_last, prev_last);
                chk("hold_idx", a_neuron_idx, prev_idx);
            end
            if (abort_addr >= 0 && a_syn_valid && int'(a_syn_addr) == abort_addr) begin
                chk("abort_idx", a_neuron_idx, 2);
                rst = 1'b1;
                @(negedge clk);
                chk("abort_valid", a_syn_valid, 0);
                chk("abort_addr", a_syn_addr, 0);
                chk("abort_last", a_syn_last, 0);
                chk("abort_idx0", a_neuron_idx, 0);
                chk("abort_nd", a_neuron_done, 0);
                chk("abort_done", a_done, 0);
                chk("abort_busy", a_busy, 0);
                chk("abort_oaddr", a_offset_addr, 0);
                rst = 1'b0;
                aborted = 1'b1;
            end else begin
                if (got_done) begin
                    tail++;
                    if (tail == 1) chk("busy_drop", a_busy, 0);
                    if (tail > 1) chk("idle_busy", a_busy, 0);
                end
                ready_a = toggle_ready ? (cyc % 2 == 0) : 1'b1;
                prev_stall = a_syn_valid && !ready_a;
                prev_addr  = a_syn_addr;
                prev_last  = a_syn_last;
                prev_idx   = a_neuron_idx;
                if (a_syn_valid && ready_a) begin
                    if (nbeat < 10) begin
                        chk("beat_addr", a_syn_addr, nbeat);
                        chk("beat_idx", a_neuron_idx, exp_idx[nbeat]);
                        chk("beat_last", a_syn_last, exp_last[nbeat]);
                    end
                    nbeat++;
                end
                if (a_neuron_done) begin
                    chk("nd_idx", a_neuron_idx, nd_cnt);
                    if (nd_cnt < 4) chk("nd_beats", nbeat, exp_nd_beats[nd_cnt]);
                    nd_cnt++;
                end
                if (a_done) begin
                    chk("done_busy", a_busy, 1);
                    chk("done_after_nd", nd_cnt, 4);
                    done_cnt++;
                    got_done = 1'b1;
                end
            end
        end
        start_a = 1'b0;
        ready_a = 1'b1;
        if (!aborted) begin
            if (!got_done) chk("timeout_a", 0, 1);
            chk("total_beats", nbeat, 10);
            chk("nd_count", nd_cnt, 4);
            chk("done_count", done_cnt, 1);
            chk("max_oaddr", max_addr, 3);
        end
    endtask

    initial begin
        int nd, nv, dn, nb, lat, maxo;
        rst     = 1'b1;
        start_a = 1'b0;
        start_z = 1'b0;
        start_o = 1'b0;
        ready_a = 1'b1;
        ready_z = 1'b1;
        ready_o = 1'b1;
        repeat (3) @(negedge clk);

        chk("rst_valid", a_syn_valid, 0);
        chk("rst_addr", a_syn_addr, 0);
        chk("rst_last", a_syn_last, 0);
        chk("rst_idx", a_neuron_idx, 0);
        chk("rst_nd", a_neuron_done, 0);
        chk("rst_done", a_done, 0);
        chk("rst_busy", a_busy, 0);
        chk("rst_oaddr", a_offset_addr, 0);
        rst = 1'b0;
        @(negedge clk);

        run_a(1'b0, 1'b0, -1);  // plain pass
        run_a(1'b1, 1'b0, -1);  // alternating ready
        run_a(1'b0, 1'b1, -1);  // start while busy
        run_a(1'b0, 1'b0, 4);   // reset during neuron 2, beat 4
        run_a(1'b0, 1'b0, -1);  // full replay after reset

        // All neurons empty: only neuron_done pulses, no beats.
        nd = 0; nv = 0; dn = 0;
        start_z = 1'b1;
        for (int c = 0; c < 200 && dn == 0; c++) begin
            @(negedge clk);
            start_z = 1'b0;
            if (z_syn_valid) nv++;
            if (z_neuron_done) begin
                chk("z_nd_idx", z_neuron_idx, nd);
                nd++;
            end
            if (z_done) dn++;
        end
        chk("z_nd_count", nd, 4);
        chk("z_valid_count", nv, 0);
        chk("z_done_count", dn, 1);

        // Single neuron: latency, two beats, offset_addr pinned at 0.
        nd = 0; dn = 0; nb = 0; lat = -1; maxo = 0;
        start_o = 1'b1;
        for (int c = 1; c < 200 && dn == 0; c++) begin
            @(negedge clk);
            start_o = 1'b0;
            if (int'(o_offset_addr) > maxo) maxo = int'(o_offset_addr);
            if (o_syn_valid) begin
                if (lat < 0) lat = c;
                chk("o_addr", o_syn_addr, nb);
                chk("o_last", o_syn_last, (nb == 1) ? 1 : 0);
                nb++;
            end
            if (o_neuron_done) begin
                chk("o_nd_idx", o_neuron_idx, 0);
                chk("o_nd_beats", nb, 2);
                nd++;
            end
            if (o_done) dn++;
        end
        chk("o_latency", lat, 4);
        chk("o_beats", nb, 2);
        chk("o_nd_count", nd, 1);
        chk("o_done_count", dn, 1);
        chk("o_max_oaddr", maxo, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
